// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline constants and helpers.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0, x0, 0

  // Pointer width for a power-of-two FIFO of the given depth.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous power-of-two FIFO with clear; the head word is visible on data_o.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PW = ptr_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [PW:0]      count_o
);

  localparam logic [PW:0] ONE  = 1;
  localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);
  localparam logic [PW-1:0] PONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == FULL);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rptr_q];

  // A push into a full FIFO is accepted when the head is popped in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Next-state pointers and occupancy; pointers wrap naturally at DEPTH.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + PONE;
    if (do_pop)  rptr_d = rptr_q + PONE;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + ONE;
      2'b01:   cnt_d = cnt_q - ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer/count registers; reset and clear both empty the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage array, written at the tail on every accepted push.
  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i && !rst_i) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: issues in-order imem requests under a credit limit, buffers
// returned words with their PCs, and hands them to decode with stall/flush.
module if_fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            pc_stall_o,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            stall_i,
  input  logic            flush_i,
  output logic            inst_valid_o,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

  logic [CW-1:0]   out_q, out_d, disc_q, disc_d;
  logic [CW-1:0]   pc_cnt, inst_cnt;
  logic [XLEN-1:0] pc_head, inst_head;
  logic            pc_full, pc_empty, inst_full, inst_empty;
  logic            grant, resp, drop, inst_push, consume, credit;
  logic [CW:0]     occupancy;
  logic            unused_ok;

  assign unused_ok = ^{pc_full, pc_empty, inst_full, inst_cnt};

  // Responses with nothing outstanding (e.g. stragglers from before a reset) are ignored.
  assign resp      = imem_rvalid_i & (out_q != '0) & ~rst_i;
  assign drop      = resp & (disc_q != '0);
  assign inst_push = resp & ~drop & ~flush_i;
  assign consume   = inst_valid_o & ~stall_i & ~flush_i;

  // Slots still owed to discarded responses count against the budget; a slot freed by
  // this cycle's consume is reusable immediately so L=1 streams at one per cycle.
  assign occupancy = {1'b0, pc_cnt} + {1'b0, disc_q} - {{CW{1'b0}}, consume};
  assign credit    = (occupancy < LIMIT);

  assign imem_req_o  = credit & ~flush_i & ~rst_i;
  assign imem_addr_o = pc_i;
  assign grant       = imem_req_o & imem_gnt_i;
  assign pc_stall_o  = ~flush_i & ~grant;

  assign inst_valid_o = ~inst_empty;
  assign inst_o       = inst_valid_o ? inst_head : NOP_INST;
  assign inst_pc_o    = inst_valid_o ? pc_head : '0;

  // Outstanding/discard bookkeeping; a flush turns every in-flight request into a discard.
  always_comb begin
    out_d  = out_q + {{(CW-1){1'b0}}, grant} - {{(CW-1){1'b0}}, resp};
    disc_d = disc_q - {{(CW-1){1'b0}}, drop};
    if (flush_i) begin
      out_d  = out_q - {{(CW-1){1'b0}}, resp};
      disc_d = out_q - {{(CW-1){1'b0}}, resp};
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q  <= '0;
      disc_q <= '0;
    end else begin
      out_q  <= out_d;
      disc_q <= disc_d;
    end
  end

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) pc_q (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (grant),
    .pop_i   (consume),
    .clear_i (flush_i),
    .data_i  (pc_i),
    .data_o  (pc_head),
    .full_o  (pc_full),
    .empty_o (pc_empty),
    .count_o (pc_cnt)
  );

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) inst_q (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (inst_push),
    .pop_i   (consume),
    .clear_i (flush_i),
    .data_i  (imem_rdata_i),
    .data_o  (inst_head),
    .full_o  (inst_full),
    .empty_o (inst_empty),
    .count_o (inst_cnt)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit (DEPTH=2): table of cycle vectors plus flush sequences.
module tb_if_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, gnt, rvalid, stall, flush;
  logic [31:0] pc, rdata;
  logic        pc_stall, req, valid;
  logic [31:0] addr, inst, inst_pc;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  if_fetch_unit #(.DEPTH(2)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .pc_i          (pc),
    .pc_stall_o    (pc_stall),
    .imem_req_o    (req),
    .imem_addr_o   (addr),
    .imem_gnt_i    (gnt),
    .imem_rvalid_i (rvalid),
    .imem_rdata_i  (rdata),
    .stall_i       (stall),
    .flush_i       (flush),
    .inst_valid_o  (valid),
    .inst_o        (inst),
    .inst_pc_o     (inst_pc)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic [31:0] pc;
    logic        gnt, rv;
    logic [31:0] rd;
    logic        stall, flush;
    logic        e_req, e_pcs, e_val;
    logic [31:0] e_inst, e_ipc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string nm, input logic r, input logic [31:0] p,
                              input logic g, input logic v, input logic [31:0] d,
                              input logic s, input logic f, input logic erq,
                              input logic eps, input logic evl, input logic [31:0] ein,
                              input logic [31:0] eip);
    vec_t x;
    x.name = nm; x.rst = r; x.pc = p; x.gnt = g; x.rv = v; x.rd = d;
    x.stall = s; x.flush = f; x.e_req = erq; x.e_pcs = eps; x.e_val = evl;
    x.e_inst = ein; x.e_ipc = eip;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Drive one cycle's inputs, check outputs mid-cycle, then let the edge happen.
  task automatic apply(input vec_t v);
    rst = v.rst; pc = v.pc; gnt = v.gnt; rvalid = v.rv; rdata = v.rd;
    stall = v.stall; flush = v.flush;
    @(negedge clk);
    chk({v.name, ".req"},      {31'd0, req},      {31'd0, v.e_req});
    chk({v.name, ".pc_stall"}, {31'd0, pc_stall}, {31'd0, v.e_pcs});
    chk({v.name, ".addr"},     addr,              v.pc);
    chk({v.name, ".valid"},    {31'd0, valid},    {31'd0, v.e_val});
    chk({v.name, ".inst"},     inst,              v.e_inst);
    chk({v.name, ".inst_pc"},  inst_pc,           v.e_ipc);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; pc = '0; gnt = 1'b0; rvalid = 1'b0; rdata = '0; stall = 1'b0; flush = 1'b0;
    @(posedge clk);
    #1;

    // reset with responses pulsed, stray response after reset, streaming
    tbl.push_back(mk("rst1",  1, 32'h0,  1, 1, 32'hBAD0_0001, 0, 0, 0, 1, 0, NOP, 32'h0));
    tbl.push_back(mk("rst2",  1, 32'h0,  1, 1, 32'hBAD0_0002, 0, 0, 0, 1, 0, NOP, 32'h0));
    tbl.push_back(mk("stray", 0, 32'h0,  0, 1, 32'hBAD0_0003, 0, 0, 1, 1, 0, NOP, 32'h0));
    tbl.push_back(mk("s0",    0, 32'h0,  1, 0, 32'h0,         0, 0, 1, 0, 0, NOP, 32'h0));
    tbl.push_back(mk("s1",    0, 32'h4,  1, 1, 32'h0000_0093, 0, 0, 1, 0, 0, NOP, 32'h0));
    tbl.push_back(mk("s2",    0, 32'h8,  1, 1, 32'h0010_0113, 0, 0, 1, 0, 1, 32'h0000_0093, 32'h0));
    tbl.push_back(mk("s3",    0, 32'hC,  0, 1, 32'h0020_0193, 0, 0, 1, 1, 1, 32'h0010_0113, 32'h4));
    tbl.push_back(mk("s4",    0, 32'hC,  0, 0, 32'h0,         0, 0, 1, 1, 1, 32'h0020_0193, 32'h8));
    tbl.push_back(mk("s5",    0, 32'hC,  0, 0, 32'h0,         0, 0, 1, 1, 0, NOP, 32'h0));
    // decode back-pressure: credit runs out after two grants
    tbl.push_back(mk("brst",  1, 32'h0,  0, 0, 32'h0,         0, 0, 0, 1, 0, NOP, 32'h0));
    tbl.push_back(mk("b0",    0, 32'h0,  1, 0, 32'h0,         1, 0, 1, 0, 0, NOP, 32'h0));
    tbl.push_back(mk("b1",    0, 32'h4,  1, 1, 32'hA000_0000, 1, 0, 1, 0, 0, NOP, 32'h0));
    tbl.push_back(mk("b2",    0, 32'h8,  1, 1, 32'hA000_0004, 1, 0, 0, 1, 1, 32'hA000_0000, 32'h0));
    tbl.push_back(mk("b3",    0, 32'h8,  1, 0, 32'h0,         1, 0, 0, 1, 1, 32'hA000_0000, 32'h0));
    tbl.push_back(mk("b4",    0, 32'h8,  1, 0, 32'h0,         0, 0, 1, 0, 1, 32'hA000_0000, 32'h0));
    tbl.push_back(mk("b5",    0, 32'hC,  0, 0, 32'h0,         0, 0, 1, 1, 1, 32'hA000_0004, 32'h4));
    // memory back-pressure: no grant for three cycles, then exactly one
    tbl.push_back(mk("m0",    0, 32'hC,  0, 1, 32'hA000_0008, 0, 0, 1, 1, 0, NOP, 32'h0));
    tbl.push_back(mk("m1",    0, 32'hC,  0, 0, 32'h0,         0, 0, 1, 1, 1, 32'hA000_0008, 32'h8));
    tbl.push_back(mk("m2",    0, 32'hC,  0, 0, 32'h0,         0, 0, 1, 1, 0, NOP, 32'h0));
    tbl.push_back(mk("m3",    0, 32'hC,  1, 0, 32'h0,         0, 0, 1, 0, 0, NOP, 32'h0));
    tbl.push_back(mk("m4",    0, 32'h10, 0, 0, 32'h0,         0, 0, 1, 1, 0, NOP, 32'h0));
    tbl.push_back(mk("m5",    0, 32'h10, 0, 1, 32'hA000_000C, 0, 0, 1, 1, 0, NOP, 32'h0));
    tbl.push_back(mk("m6",    0, 32'h10, 0, 0, 32'h0,         0, 0, 1, 1, 1, 32'hA000_000C, 32'hC));
    tbl.push_back(mk("m7",    0, 32'h10, 0, 0, 32'h0,         0, 0, 1, 1, 0, NOP, 32'h0));

    foreach (tbl[i]) apply(tbl[i]);

    // flush with two requests in flight (L=3), redirect to 0x100
    apply(mk("frst", 1, 32'h0,   0, 0, 32'h0,         0, 0, 0, 1, 0, NOP, 32'h0));
    apply(mk("f0",   0, 32'h0,   1, 0, 32'h0,         0, 0, 1, 0, 0, NOP, 32'h0));
    apply(mk("f1",   0, 32'h4,   1, 0, 32'h0,         0, 0, 1, 0, 0, NOP, 32'h0));
    apply(mk("f2",   0, 32'h8,   1, 0, 32'h0,         0, 1, 0, 0, 0, NOP, 32'h0));
    apply(mk("f3",   0, 32'h100, 1, 1, 32'hDEAD_0000, 0, 0, 0, 1, 0, NOP, 32'h0));
    apply(mk("f4",   0, 32'h100, 1, 1, 32'hDEAD_0004, 0, 0, 1, 0, 0, NOP, 32'h0));
    apply(mk("f5",   0, 32'h104, 0, 0, 32'h0,         0, 0, 1, 1, 0, NOP, 32'h0));
    apply(mk("f6",   0, 32'h104, 0, 1, 32'hC000_0100, 0, 0, 1, 1, 0, NOP, 32'h0));
    apply(mk("f7",   0, 32'h104, 0, 0, 32'h0,         0, 0, 1, 1, 1, 32'hC000_0100, 32'h100));
    apply(mk("f8",   0, 32'h104, 0, 0, 32'h0,         0, 0, 1, 1, 0, NOP, 32'h0));

    // flush + response + stall together: that response is not counted, one discard left
    apply(mk("hrst", 1, 32'h0,   0, 0, 32'h0,         0, 0, 0, 1, 0, NOP, 32'h0));
    apply(mk("h0",   0, 32'h0,   1, 0, 32'h0,         0, 0, 1, 0, 0, NOP, 32'h0));
    apply(mk("h1",   0, 32'h4,   1, 0, 32'h0,         0, 0, 1, 0, 0, NOP, 32'h0));
    apply(mk("h2",   0, 32'h8,   1, 1, 32'hDEAD_1000, 1, 1, 0, 0, 0, NOP, 32'h0));
    apply(mk("h3",   0, 32'h200, 1, 0, 32'h0,         0, 0, 1, 0, 0, NOP, 32'h0));
    apply(mk("h4",   0, 32'h204, 0, 1, 32'hDEAD_1004, 0, 0, 0, 1, 0, NOP, 32'h0));
    apply(mk("h5",   0, 32'h204, 0, 1, 32'hD000_0200, 0, 0, 1, 1, 0, NOP, 32'h0));
    apply(mk("h6",   0, 32'h204, 0, 0, 32'h0,         0, 0, 1, 1, 1, 32'hD000_0200, 32'h200));
    apply(mk("h7",   0, 32'h204, 0, 0, 32'h0,         0, 0, 1, 1, 0, NOP, 32'h0));

    // flush beats stall with a buffered instruction; later stray response ignored
    apply(mk("grst", 1, 32'h0,   0, 0, 32'h0,         0, 0, 0, 1, 0, NOP, 32'h0));
    apply(mk("g0",   0, 32'h0,   1, 0, 32'h0,         0, 0, 1, 0, 0, NOP, 32'h0));
    apply(mk("g1",   0, 32'h4,   1, 1, 32'hE000_0000, 0, 0, 1, 0, 0, NOP, 32'h0));
    apply(mk("g2",   0, 32'h8,   0, 0, 32'h0,         1, 0, 0, 1, 1, 32'hE000_0000, 32'h0));
    apply(mk("g3",   0, 32'h8,   1, 1, 32'hE000_0004, 1, 1, 0, 0, 1, 32'hE000_0000, 32'h0));
    apply(mk("g4",   0, 32'h300, 0, 0, 32'h0,         1, 0, 1, 1, 0, NOP, 32'h0));
    apply(mk("g5",   0, 32'h300, 0, 1, 32'hBAD0_0005, 0, 0, 1, 1, 0, NOP, 32'h0));
    apply(mk("g6",   0, 32'h300, 0, 0, 32'h0,         0, 0, 1, 1, 0, NOP, 32'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
